dcache_ctrl: RTL

//   Direct-mapped, write-through, no-write-allocate data cache with one-word lines.

---
 rtl/dcache_ctrl_if.sv | 31 +++
 rtl/dcache_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and RAM-side bus bundle for the data cache controller
interface dcache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // Cache controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ack,
    output cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_din,
    output hit_count, miss_count
  );

  // Environment side: CPU memory stage plus data RAM.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ack,
    input  cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_din,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-allocate data cache, one-word lines
module dcache_ctrl #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM} state_t;

  state_t                 state, state_nx;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];
  logic                   refill_done;

  logic [INDEX_WIDTH-1:0] idx, fill_idx;
  logic [TAG_WIDTH-1:0]   tag, fill_tag;
  logic                   hit;
  logic                   fill;
  logic                   load;
  logic                   wr_hit;
  logic                   cnt_hit;
  logic                   cnt_miss;
  logic                   stall;
  logic                   unused_addr_bits;

  // CPU lookup uses the live address; the refill uses the latched RAM address.
  assign idx      = bus.cpu_addr[INDEX_WIDTH+1:2];
  assign tag      = bus.cpu_addr[31:INDEX_WIDTH+2];
  assign fill_idx = bus.mem_addr[INDEX_WIDTH+1:2];
  assign fill_tag = bus.mem_addr[31:INDEX_WIDTH+2];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);
  assign fill     = (state == RD_MEM) && bus.mem_ack;
  assign unused_addr_bits = &{1'b0, bus.cpu_addr[1:0], bus.mem_addr[1:0]};

  assign bus.cpu_dout  = hit ? data_mem[idx] : 32'h0;
  assign bus.cpu_stall = stall;
  // Dropping cs in the ack cycle returns the RAM to idle instead of restarting.
  assign bus.mem_cs    = (state != IDLE) && !bus.mem_ack;

  // Next state, stall and counter/latch strobes.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    load     = 1'b0;
    wr_hit   = 1'b0;
    cnt_hit  = 1'b0;
    cnt_miss = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            stall    = 1'b1;
            load     = 1'b1;
            state_nx = WR_MEM;
            wr_hit   = hit;
            cnt_hit  = hit;
            cnt_miss = !hit;
          end else if (hit) begin
            // The hit right after a refill is the retiring miss, already counted.
            cnt_hit = !refill_done;
          end else begin
            stall    = 1'b1;
            load     = 1'b1;
            cnt_miss = 1'b1;
            state_nx = RD_MEM;
          end
        end
      end
      RD_MEM: begin
        stall = 1'b1;
        if (bus.mem_ack) state_nx = IDLE;
      end
      WR_MEM: begin
        stall = !bus.mem_ack;
        if (bus.mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state, valid bits, counters and the registered RAM request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= '0;
      refill_done    <= 1'b0;
      bus.hit_count  <= 32'h0;
      bus.miss_count <= 32'h0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_din    <= 32'h0;
    end else begin
      state       <= state_nx;
      refill_done <= fill;
      if (fill) valid[fill_idx] <= 1'b1;
      if (cnt_hit) bus.hit_count <= bus.hit_count + 32'h1;
      if (cnt_miss) bus.miss_count <= bus.miss_count + 32'h1;
      if (load) begin
        bus.mem_we   <= bus.cpu_we;
        bus.mem_addr <= {bus.cpu_addr[31:2], 2'b00};
        if (bus.cpu_we) bus.mem_din <= bus.cpu_din;
      end
    end
  end

  // Tag/data arrays carry no reset; writes are blocked while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && wr_hit) data_mem[idx] <= bus.cpu_din;
    if (!rst && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_dout;
    end
  end
endmodule
